// File: rtl/complex_addsub_pipe_pkg.sv
// Shared types and constants for the complex add/sub pipeline.
// Mode encodings and {real, imag} field positions.
package complex_addsub_pipe_pkg;

  localparam logic [1:0] MODE_WRAP  = 2'd0;
  localparam logic [1:0] MODE_SAT   = 2'd1;
  localparam logic [1:0] MODE_SCALE = 2'd2;

  // Field index within a packed operand; field i is [i*W +: W].
  localparam int RE_POS = 1;
  localparam int IM_POS = 0;

endpackage

// File: rtl/complex_addsub_comp.sv
// Single-component signed add/sub with wrap, saturate or halve.
// Purely combinational; one instance per complex component.
module complex_addsub_comp
  import complex_addsub_pipe_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic [1:0]   mode,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W:0] ea;
  logic [W:0] eb;
  logic [W:0] s;

  assign ea  = {a[W-1], a};
  assign eb  = {b[W-1], b};
  assign s   = sub ? (ea - eb) : (ea + eb);
  assign ovf = s[W] ^ s[W-1];

  // The reserved mode falls through to wrap.
  always_comb begin
    y = s[W-1:0];
    unique case (1'b1)
      (mode == MODE_SAT) && ovf:
        y = s[W] ? {1'b1, {(W-1){1'b0}}}
                 : {1'b0, {(W-1){1'b1}}};
      (mode == MODE_SCALE):
        y = s[W:1];
      default: ;
    endcase
  end

endmodule

// File: rtl/complex_addsub_pipe.sv
// Two-stage valid/ready pipeline computing complex A +/- B.
// Per-beat overflow handling and a saturating overflow counter.
module complex_addsub_pipe
  import complex_addsub_pipe_pkg::*;
#(
  parameter int W     = 11,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   A,
  input  logic [2*W-1:0]   B,
  input  logic             sub,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   Y,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  logic [2*W-1:0] a_q;
  logic [2*W-1:0] b_q;
  logic           sub_q;
  logic [1:0]     mode_q;
  logic           v1;
  logic           v2;
  logic [2*W-1:0] y_q;
  logic           ovf_q;

  logic           s2_en;
  logic           in_xfer;
  logic           out_xfer;
  logic [W-1:0]   y_re;
  logic [W-1:0]   y_im;
  logic           ovf_re;
  logic           ovf_im;

  assign s2_en    = !v2 || out_ready;
  assign in_ready = !v1 || s2_en;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = v2 && out_ready;

  complex_addsub_comp #(.W(W)) u_re (
    .a    (a_q[RE_POS*W +: W]),
    .b    (b_q[RE_POS*W +: W]),
    .sub  (sub_q),
    .mode (mode_q),
    .y    (y_re),
    .ovf  (ovf_re)
  );

  complex_addsub_comp #(.W(W)) u_im (
    .a    (a_q[IM_POS*W +: W]),
    .b    (b_q[IM_POS*W +: W]),
    .sub  (sub_q),
    .mode (mode_q),
    .y    (y_im),
    .ovf  (ovf_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      mode_q <= MODE_WRAP;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_xfer) begin
        a_q    <= A;
        b_q    <= B;
        sub_q  <= sub;
        mode_q <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (s2_en) begin
      v2 <= v1;
      if (v1) begin
        y_q   <= {y_re, y_im};
        ovf_q <= ovf_re || ovf_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_xfer && ovf_q && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign out_valid = v2;
  assign Y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Directed self-checking bench for complex_addsub_pipe (W=11).
// A second instance with CNT_W=4 exercises counter saturation.
module tb_complex_addsub_pipe;
  import complex_addsub_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready4;
  logic [21:0] A;
  logic [21:0] B;
  logic        sub;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_valid4;
  logic        out_ready;
  logic [21:0] Y;
  logic [21:0] Y4;
  logic        ovf;
  logic        ovf4;
  logic [15:0] ovf_cnt;
  logic [3:0]  ovf_cnt4;
  logic        cnt_clr;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  complex_addsub_pipe #(.W(11), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  complex_addsub_pipe #(.W(11), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .A(A), .B(B), .sub(sub), .mode(mode),
    .out_valid(out_valid4), .out_ready(out_ready),
    .Y(Y4), .ovf(ovf4), .ovf_cnt(ovf_cnt4), .cnt_clr(cnt_clr)
  );

  function automatic logic [21:0] pk(input int re, input int im);
    logic [10:0] r;
    logic [10:0] i;
    r = re[10:0];
    i = im[10:0];
    return {r, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(
    input  logic [21:0] a,
    input  logic [21:0] b,
    input  logic        s,
    input  logic [1:0]  m,
    output logic [21:0] y,
    output logic        o,
    output int          lat
  );
    A = a; B = b; sub = s; mode = m;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = -1; y = '0; o = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (out_valid) begin
        lat = k; y = Y; o = ovf;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cnt_clr = 1'b0; A = '0; B = '0; sub = 1'b0; mode = MODE_WRAP;
    step(); step();
    vec++;
    if (out_valid !== 1'b0 || Y !== 22'd0 || ovf !== 1'b0) begin
      err++;
      $display("FAIL reset_out: valid=%b Y=%h ovf=%b want 0 0 0",
               out_valid, Y, ovf);
    end
    vec++;
    if (ovf_cnt !== 16'd0 || ovf_cnt4 !== 4'd0) begin
      err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0", ovf_cnt, ovf_cnt4);
    end
    rst_n = 1'b1;
    step();
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [21:0] y;
    logic        o;
    int          lat;
    run_beat(pk(1023, 0), pk(1, 0), 1'b0, MODE_WRAP, y, o, lat);
    vec++;
    if (y !== pk(-1024, 0) || o !== 1'b1 || lat !== 2) begin
      err++;
      $display("FAIL wrap_pos: Y=%h ovf=%b lat=%0d want %h 1 2",
               y, o, lat, pk(-1024, 0));
    end
    vec++;
    if (ovf_cnt !== 16'd1) begin
      err++;
      $display("FAIL wrap_cnt: got %0d want 1", ovf_cnt);
    end
    run_beat(pk(100, -200), pk(-50, 30), 1'b1, MODE_WRAP, y, o, lat);
    vec++;
    if (y !== pk(150, -230) || o !== 1'b0) begin
      err++;
      $display("FAIL wrap_sub: Y=%h ovf=%b want %h 0", y, o, pk(150, -230));
    end
    run_beat(pk(-1024, 5), pk(1, 3), 1'b1, 2'd3, y, o, lat);
    vec++;
    if (y !== pk(1023, 2) || o !== 1'b1) begin
      err++;
      $display("FAIL mode3_wrap: Y=%h ovf=%b want %h 1", y, o, pk(1023, 2));
    end
  endtask

  task automatic test_sat();
    logic [21:0] y;
    logic        o;
    int          lat;
    run_beat(pk(1023, -1024), pk(1, 0), 1'b0, MODE_SAT, y, o, lat);
    vec++;
    if (y !== pk(1023, -1024) || o !== 1'b1) begin
      err++;
      $display("FAIL sat_pos: Y=%h ovf=%b want %h 1", y, o, pk(1023, -1024));
    end
    run_beat(pk(0, -1024), pk(0, 1), 1'b1, MODE_SAT, y, o, lat);
    vec++;
    if (y !== pk(0, -1024) || o !== 1'b1) begin
      err++;
      $display("FAIL sat_neg: Y=%h ovf=%b want %h 1", y, o, pk(0, -1024));
    end
    run_beat(pk(-1024, 1000), pk(0, 23), 1'b0, MODE_SAT, y, o, lat);
    vec++;
    if (y !== pk(-1024, 1023) || o !== 1'b0) begin
      err++;
      $display("FAIL sat_edge: Y=%h ovf=%b want %h 0", y, o, pk(-1024, 1023));
    end
  endtask

  task automatic test_scale();
    logic [21:0] y;
    logic        o;
    int          lat;
    run_beat(pk(1023, -1024), pk(1, -1), 1'b0, MODE_SCALE, y, o, lat);
    vec++;
    if (y !== pk(512, -513) || o !== 1'b1) begin
      err++;
      $display("FAIL scale_ovf: Y=%h ovf=%b want %h 1", y, o, pk(512, -513));
    end
    run_beat(pk(3, -3), pk(0, 0), 1'b0, MODE_SCALE, y, o, lat);
    vec++;
    if (y !== pk(1, -2) || o !== 1'b0) begin
      err++;
      $display("FAIL scale_odd: Y=%h ovf=%b want %h 0", y, o, pk(1, -2));
    end
  endtask

  task automatic test_back_to_back();
    int          sent;
    int          recv;
    int          first;
    logic        stall;
    logic [21:0] ey;
    sent = 0; recv = 0; first = -1; stall = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = (sent < 8);
      A = pk(sent + 1, -(sent + 1));
      B = pk(10, 20);
      sub = 1'b0; mode = MODE_WRAP;
      #1;
      if (in_valid && !in_ready) stall = 1'b1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        ey = pk(recv + 11, 19 - recv);
        vec++;
        if (Y !== ey || ovf !== 1'b0) begin
          err++;
          $display("FAIL stream_y[%0d] cyc %0d: Y=%h ovf=%b want %h 0",
                   recv, cyc, Y, ovf, ey);
        end
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    vec++;
    if (recv !== 8 || sent !== 8 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL stream_count: sent=%0d recv=%0d valid=%b want 8 8 0",
               sent, recv, out_valid);
    end
    vec++;
    if (stall !== 1'b1 || first !== 2) begin
      err++;
      $display("FAIL stream_flow: stall=%b first=%0d want 1 2", stall, first);
    end
  endtask

  task automatic test_reset_midstream();
    logic [21:0] y;
    logic        o;
    int          lat;
    out_ready = 1'b0;
    in_valid = 1'b1;
    A = pk(7, 7); B = pk(1, 1); sub = 1'b0; mode = MODE_WRAP;
    step(); step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vec++;
    if (out_valid !== 1'b0 || ovf_cnt !== 16'd0 || Y !== 22'd0) begin
      err++;
      $display("FAIL midrst: valid=%b cnt=%0d Y=%h want 0 0 0",
               out_valid, ovf_cnt, Y);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    vec++;
    if (out_valid !== 1'b0) begin
      err++;
      $display("FAIL midrst_flush: out_valid=%b want 0", out_valid);
    end
    run_beat(pk(-5, 9), pk(2, -4), 1'b1, MODE_WRAP, y, o, lat);
    vec++;
    if (y !== pk(-7, 13) || o !== 1'b0 || lat !== 2) begin
      err++;
      $display("FAIL midrst_next: Y=%h ovf=%b lat=%0d want %h 0 2",
               y, o, lat, pk(-7, 13));
    end
  endtask

  task automatic test_cnt_sat();
    int          outs;
    logic        stall;
    logic [21:0] y;
    logic        o;
    int          lat;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    outs = 0; stall = 1'b0;
    out_ready = 1'b1;
    A = pk(1023, 0); B = pk(1, 0); sub = 1'b0; mode = MODE_WRAP;
    for (int i = 0; i < 21; i++) begin
      in_valid = (i < 17);
      #1;
      if (in_valid && !in_ready) stall = 1'b1;
      if (out_valid) outs++;
      step();
    end
    in_valid = 1'b0;
    vec++;
    if (outs !== 17 || stall !== 1'b0) begin
      err++;
      $display("FAIL b2b_thru: outs=%0d stall=%b want 17 0", outs, stall);
    end
    vec++;
    if (ovf_cnt4 !== 4'd15) begin
      err++;
      $display("FAIL cnt_sat4: got %0d want 15", ovf_cnt4);
    end
    vec++;
    if (ovf_cnt !== 16'd17) begin
      err++;
      $display("FAIL cnt_17: got %0d want 17", ovf_cnt);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;
    vec++;
    if (out_valid !== 1'b1 || ovf !== 1'b1) begin
      err++;
      $display("FAIL clr_setup: valid=%b ovf=%b want 1 1", out_valid, ovf);
    end
    step();
    cnt_clr = 1'b0;
    vec++;
    if (ovf_cnt4 !== 4'd0 || ovf_cnt !== 16'd0) begin
      err++;
      $display("FAIL clr_wins: got %0d/%0d want 0", ovf_cnt4, ovf_cnt);
    end
    run_beat(pk(1023, 0), pk(1, 0), 1'b0, MODE_WRAP, y, o, lat);
    vec++;
    if (ovf_cnt4 !== 4'd1 || o !== 1'b1) begin
      err++;
      $display("FAIL cnt_after_clr: cnt=%0d ovf=%b want 1 1", ovf_cnt4, o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_sat();
    test_scale();
    test_back_to_back();
    test_reset_midstream();
    test_cnt_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
